axi_write_master: RTL and testbench

AXI3 write-channel master that turns a single-command request interface plus a data stream into AW/W/B handshakes. It feeds the team's slave-write model.
- Exactly one burst is outstanding at a time: AW, then all W beats, then B.
- The B result is returned on a response strobe.
- Acts as the upstream stimulus/driver stage in the AXI verification harness.

---
 rtl/axi_write_master_pkg.sv | 28 ++
 rtl/axi_write_master_if.sv | 50 +++++
 rtl/axi_write_master_beat_counter.sv | 24 ++
 rtl/axi_write_master.sv | 192 +++++++++++++++++++
 tb/tb_axi_write_master.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_write_master_pkg.sv
// Purpose : shared types/constants for the single-outstanding AXI3 write master.
// Latency : n/a (declarations only).
// Backpressure: n/a. Contents: FSM state enum, BRESP/BURST encodings, AW sideband constants.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Fixed AW sideband: normal access, bufferable + modifiable, unprivileged secure data.
    localparam logic       AW_LOCK  = 1'b0;
    localparam logic [3:0] AW_CACHE = 4'b0011;
    localparam logic [2:0] AW_PROT  = 3'b000;
    localparam logic [3:0] AW_QOS   = 4'b0000;

endpackage

// File: rtl/axi_write_master_if.sv
// Purpose : AXI3 write-channel bundle (AW, W, B) between the write master and a slave.
// Latency : n/a (wires only).
// Backpressure: valid/ready on every channel. Modports: master drives AW/W/bready, slave the rest.
interface axi_write_master_if #(
    parameter int ID_W   = 12,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                awvalid;
    logic                awready;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [ID_W-1:0]     awid;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [ID_W-1:0]     wid;
    logic                wlast;

    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic [ID_W-1:0]     bid;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos,
        input  awready,
        output wvalid, wdata, wstrb, wid, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos,
        output awready,
        input  wvalid, wdata, wstrb, wid, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );
endinterface

// File: rtl/axi_write_master_beat_counter.sv
// Purpose : W-beat counter with clear, increment and last-beat compare against the burst length.
// Latency : cnt updates one cycle after inc; last is combinational from cnt and len.
// Backpressure: none; holds at len once the last beat is taken so a 256-beat burst never wraps.
module axi_wr_beat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    input  logic [7:0] len,
    output logic [7:0] cnt,
    output logic       last
);
    assign last = (cnt == len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (inc && !last) begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/axi_write_master.sv
// Purpose : AXI3 write master, one burst outstanding: cmd -> AW -> W beats -> B -> rsp pulse.
// Latency : len=0, all ready: cmd at T, AW at T+1, W at T+2, B at T+3, rsp_valid at T+4.
// Backpressure: cmd_ready only in IDLE; W is a combinational pass-through of wr_data/wready.
// Ports: clk, m_axi_aresetn; cmd_* request; wr_data* stream; m_axi (AXI master modport);
//        rsp_* result. Optional AXI_WR_TIMEOUT_EN adds a B watchdog and the timeout_err port.
module axi_write_master
    import axi_wr_pkg::*;
#(
    parameter int ID_W           = 12,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                m_axi_aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic                wr_data_valid,
    output logic                wr_data_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    axi_write_master_if.master  m_axi,
    output logic                rsp_valid,
    output logic [1:0]          rsp_resp,
    output logic [ID_W-1:0]     rsp_id
`ifdef AXI_WR_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit watchdog counter");
    end

    wr_state_e         state_q, state_d;
    logic              awvalid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [ID_W-1:0]   id_q;
    logic              rsp_valid_q;
    logic [1:0]        rsp_resp_q;
    logic [ID_W-1:0]   rsp_id_q;

    logic       cmd_fire, w_fire, b_fire, tmo_hit;
    logic       wvalid_c, bready_c;
    logic [7:0] beat_cnt;
    logic       beat_last;

    axi_wr_beat_counter u_beat_cnt (
        .clk   (clk),
        .rst_n (m_axi_aresetn),
        .clear (cmd_fire),
        .inc   (w_fire),
        .len   (len_q),
        .cnt   (beat_cnt),
        .last  (beat_last)
    );

`ifdef AXI_WR_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        timeout_err_q;

    // Counts RESP cycles; held at zero elsewhere so every entry to RESP starts fresh.
    always_ff @(posedge clk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            tmo_cnt <= 16'd0;
        end else if (state_q != RESP) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th RESP cycle if the slave still has not answered.
    assign tmo_hit     = (state_q == RESP) && !m_axi.bvalid &&
                         (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        wvalid_c      = 1'b0;
        wr_data_ready = 1'b0;
        bready_c      = 1'b0;
        cmd_fire      = 1'b0;
        w_fire        = 1'b0;
        b_fire        = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                cmd_fire  = cmd_valid;
                if (cmd_valid) state_d = ADDR;
            end
            ADDR: begin
                if (awvalid_q && m_axi.awready) state_d = DATA;
            end
            DATA: begin
                wvalid_c      = wr_data_valid;
                wr_data_ready = m_axi.wready;
                w_fire        = wr_data_valid && m_axi.wready;
                if (w_fire && beat_last) state_d = RESP;
            end
            RESP: begin
                bready_c = 1'b1;
                b_fire   = m_axi.bvalid;
                if (m_axi.bvalid || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'd0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= 2'd0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            if (cmd_fire) begin
                awvalid_q <= 1'b1;
                addr_q    <= cmd_addr;
                len_q     <= cmd_len;
                size_q    <= cmd_size;
                burst_q   <= cmd_burst;
                id_q      <= cmd_id;
            end
            if (state_q == ADDR && m_axi.awready) begin
                awvalid_q <= 1'b0;
            end
            if (b_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_resp_q  <= m_axi.bresp;
                rsp_id_q    <= m_axi.bid;
            end else if (tmo_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_resp_q  <= RESP_SLVERR;
                rsp_id_q    <= id_q;
            end
        end
    end

`ifdef AXI_WR_TIMEOUT_EN
    always_ff @(posedge clk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            timeout_err_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err_q <= 1'b1;
        end
    end
`endif

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = size_q;
    assign m_axi.awburst = burst_q;
    assign m_axi.awid    = id_q;
    assign m_axi.awlock  = AW_LOCK;
    assign m_axi.awcache = AW_CACHE;
    assign m_axi.awprot  = AW_PROT;
    assign m_axi.awqos   = AW_QOS;

    assign m_axi.wvalid  = wvalid_c;
    assign m_axi.wdata   = wr_data;
    assign m_axi.wstrb   = wr_strb;
    assign m_axi.wid     = id_q;
    assign m_axi.wlast   = (state_q == DATA) && beat_last;

    assign m_axi.bready  = bready_c;

    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_axi_write_master.sv
// Purpose : directed self-checking bench for axi_write_master (bench plays the AXI slave).
// Latency : inputs driven and outputs checked at the falling edge, away from the active edge.
// Backpressure: exercised via toggled wready, held-off awready and delayed bvalid.
module tb_axi_write_master;
    localparam int ID_W   = 12;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [7:0]          cmd_len;
    logic [2:0]          cmd_size;
    logic [1:0]          cmd_burst;
    logic [ID_W-1:0]     cmd_id;
    logic                wr_data_valid;
    logic                wr_data_ready;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                rsp_valid;
    logic [1:0]          rsp_resp;
    logic [ID_W-1:0]     rsp_id;
`ifdef AXI_WR_TIMEOUT_EN
    logic                timeout_err;
`endif

    int checks = 0;
    int errors = 0;
    int beats;
    int cyc;

    always #5 clk = ~clk;

    axi_write_master_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axi ();

    axi_write_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(256)) dut (
        .clk           (clk),
        .m_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_size      (cmd_size),
        .cmd_burst     (cmd_burst),
        .cmd_id        (cmd_id),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .m_axi         (m_axi),
        .rsp_valid     (rsp_valid),
        .rsp_resp      (rsp_resp),
        .rsp_id        (rsp_id)
`ifdef AXI_WR_TIMEOUT_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [11:0] id);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_id    = id;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0; cmd_id = '0;
        wr_data_valid = 1'b0; wr_data = '0; wr_strb = '0;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00; m_axi.bid = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_awvalid", m_axi.awvalid, 0);
        chk("rst_awaddr", m_axi.awaddr, 0);
        chk("rst_awid", m_axi.awid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wvalid", m_axi.wvalid, 0);
        chk("rst_bready", m_axi.bready, 0);
        @(negedge clk); rst_n = 1'b1;

        // ---- single beat, all ready: latency T..T+4 ----
        @(negedge clk);
        send_cmd(32'h0000_1000, 8'd0, 3'd2, 2'b01, 12'h005);
        m_axi.awready = 1'b1; m_axi.wready = 1'b1;
        wr_data_valid = 1'b1; wr_data = 32'hA5A5_0001; wr_strb = 4'hF;
        #1 chk("t0_cmd_ready", cmd_ready, 1);
        @(negedge clk); cmd_valid = 1'b0;
        #1;
        chk("t1_awvalid", m_axi.awvalid, 1);
        chk("t1_awaddr", m_axi.awaddr, 32'h0000_1000);
        chk("t1_awlen", m_axi.awlen, 0);
        chk("t1_awid", m_axi.awid, 12'h005);
        chk("t1_awcache", m_axi.awcache, 4'b0011);
        chk("t1_wvalid", m_axi.wvalid, 0);
        chk("t1_cmd_ready", cmd_ready, 0);
        @(negedge clk); #1;
        chk("t2_awvalid", m_axi.awvalid, 0);
        chk("t2_wvalid", m_axi.wvalid, 1);
        chk("t2_wlast", m_axi.wlast, 1);
        chk("t2_wdata", m_axi.wdata, 32'hA5A5_0001);
        chk("t2_wid", m_axi.wid, 12'h005);
        chk("t2_bready", m_axi.bready, 0);
        @(negedge clk); #1;
        chk("t3_bready", m_axi.bready, 1);
        chk("t3_wvalid", m_axi.wvalid, 0);
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b00; m_axi.bid = 12'h005;
        @(negedge clk); m_axi.bvalid = 1'b0;
        #1;
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_resp", rsp_resp, 2'b00);
        chk("t4_rsp_id", rsp_id, 12'h005);
        chk("t4_cmd_ready", cmd_ready, 1);
        @(negedge clk); #1;
        chk("t5_rsp_pulse_end", rsp_valid, 0);

        // ---- len=3 with wready toggling; SLVERR response with mismatched bid ----
        @(negedge clk);
        send_cmd(32'h0000_3000, 8'd3, 3'd2, 2'b01, 12'h0AB);
        @(negedge clk); cmd_valid = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 4 && cyc < 40) begin
            @(negedge clk);
            m_axi.wready = (cyc % 2 == 0);
            wr_data = 32'h100 + beats;
            #1;
            chk("l3_wvalid", m_axi.wvalid, 1);
            chk("l3_rdy_mirror", wr_data_ready, m_axi.wready);
            chk("l3_wlast", m_axi.wlast, (beats == 3));
            if (m_axi.wvalid && m_axi.wready) beats++;
            cyc++;
        end
        chk("l3_beat_count", beats, 4);
        m_axi.wready = 1'b1;
        @(negedge clk); #1;
        chk("l3_bready", m_axi.bready, 1);
        chk("l3_wvalid_resp", m_axi.wvalid, 0);
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b10; m_axi.bid = 12'h007;

        // Response cycle; a new command is offered in the same cycle (back-to-back).
        @(negedge clk);
        m_axi.bvalid = 1'b0;
        send_cmd(32'h2000_0040, 8'd1, 3'd2, 2'b01, 12'h123);
        m_axi.awready = 1'b0;
        #1;
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_resp", rsp_resp, 2'b10);
        chk("err_rsp_id", rsp_id, 12'h007);
        chk("err_cmd_ready", cmd_ready, 1);

        // ---- AW stalled 10 cycles; stray cmd and bvalid are ignored ----
        @(negedge clk);
        cmd_addr = 32'hDEAD_0000;
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b01; m_axi.bid = 12'h123;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("aw_hold_valid", m_axi.awvalid, 1);
            chk("aw_hold_addr", m_axi.awaddr, 32'h2000_0040);
            chk("aw_hold_len", m_axi.awlen, 1);
            chk("aw_hold_burst", m_axi.awburst, 2'b01);
            chk("aw_hold_wvalid", m_axi.wvalid, 0);
            chk("aw_hold_bready", m_axi.bready, 0);
            chk("aw_hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        m_axi.awready = 1'b1;
        #1 chk("aw_release_valid", m_axi.awvalid, 1);
        @(negedge clk); #1;
        chk("aw_done_awvalid", m_axi.awvalid, 0);
        chk("l1_beat0_wvalid", m_axi.wvalid, 1);
        chk("l1_beat0_wlast", m_axi.wlast, 0);
        @(negedge clk); #1;
        chk("l1_beat1_wlast", m_axi.wlast, 1);
        @(negedge clk); #1;
        chk("l1_bready", m_axi.bready, 1);
        @(negedge clk);
        m_axi.bvalid = 1'b0;
        #1;
        chk("l1_rsp_valid", rsp_valid, 1);
        chk("l1_rsp_resp", rsp_resp, 2'b01);
        chk("l1_rsp_id", rsp_id, 12'h123);

        // ---- reset during beat 2 of len=7 ----
        @(negedge clk);
        send_cmd(32'h0000_4000, 8'd7, 3'd2, 2'b01, 12'h009);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        chk("mid_beat2_wvalid", m_axi.wvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", m_axi.awvalid, 0);
        chk("mid_rst_wvalid", m_axi.wvalid, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        m_axi.bvalid = 1'b1; m_axi.bid = 12'h009; m_axi.bresp = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_bready", m_axi.bready, 0);
            chk("post_rst_idle", cmd_ready, 1);
        end
        m_axi.bvalid = 1'b0;

`ifdef AXI_WR_TIMEOUT_EN
        // ---- watchdog: bvalid never arrives ----
        @(negedge clk);
        send_cmd(32'h0000_5000, 8'd0, 3'd2, 2'b01, 12'h0C3);
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        #1 chk("tmo_err_before", timeout_err, 0);
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) break;
            if (m_axi.bready) cyc++;
        end
        chk("tmo_resp_cycles", cyc, 256);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_resp", rsp_resp, 2'b10);
        chk("tmo_rsp_id", rsp_id, 12'h0C3);
        chk("tmo_err_sticky", timeout_err, 1);
        chk("tmo_idle", cmd_ready, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
